ili_cmd_seq: RTL and testbench

ILI_CMD_SEQ -- requirements
Module: ili_cmd_seq

---
 rtl/ili_cmd_seq.sv | 206 ++++++++++++++++++++
 tb/tb_ili_cmd_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ili_cmd_seq.sv
// ILI9341 command sequencer: plays the fixed init table, then repeatedly sends a
// full-screen window setup and fills it with FILL_COLOR. ILI_CMD_DELAY_EN enables real DLY waits.
module ili_cmd_seq #(
  parameter int          DW                = 8,
  parameter int          DELAY_UNIT_CYCLES = 100000,
  parameter int          H_RES             = 240,
  parameter int          V_RES             = 320,
  parameter logic [15:0] FILL_COLOR        = 16'hF800
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_send_comm_ena,
  input  logic          i_command,
  input  logic          i_spi_ready,
  output logic          o_spi_valid,
  output logic [DW-1:0] o_spi_data,
  output logic          o_spi_dc,
  output logic          o_command_sent,
  output logic          o_frame_done,
  output logic          o_busy
);

  typedef enum logic [2:0] {IDLE, FETCH, SEND, DELAY, DONE, PIXEL} state_t;
  typedef enum logic [1:0] {E_CMD, E_DAT, E_DLY, E_END} etype_t;

  localparam int          NPIX   = H_RES * V_RES;
  localparam int          PCW    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [15:0] H_LAST = 16'(H_RES - 1);
  localparam logic [15:0] V_LAST = 16'(V_RES - 1);

  state_t          state_q;
  logic [3:0]      ptr_q;
  logic            loop_q;
  logic [PCW-1:0]  pix_q;
  logic            lo_byte_q;
  logic            valid_q;
  logic [DW-1:0]   data_q;
  logic            dc_q;
  logic            sent_q;
  logic            fdone_q;
`ifdef ILI_CMD_DELAY_EN
  localparam int   DCW = $clog2(255 * DELAY_UNIT_CYCLES + 1);
  logic [DCW-1:0]  dly_cnt_q;
`endif

  logic [9:0] ent;
  logic       xfer;

  assign xfer = valid_q & i_spi_ready;

  // Table entry {type, value}; the loop table's END marks the start of pixel data.
  always_comb begin
    ent = {E_END, 8'h00};
    if (loop_q) begin
      case (ptr_q)
        4'd0:    ent = {E_CMD, 8'h2A};
        4'd1:    ent = {E_DAT, 8'h00};
        4'd2:    ent = {E_DAT, 8'h00};
        4'd3:    ent = {E_DAT, H_LAST[15:8]};
        4'd4:    ent = {E_DAT, H_LAST[7:0]};
        4'd5:    ent = {E_CMD, 8'h2B};
        4'd6:    ent = {E_DAT, 8'h00};
        4'd7:    ent = {E_DAT, 8'h00};
        4'd8:    ent = {E_DAT, V_LAST[15:8]};
        4'd9:    ent = {E_DAT, V_LAST[7:0]};
        4'd10:   ent = {E_CMD, 8'h2C};
        default: ent = {E_END, 8'h00};
      endcase
    end else begin
      case (ptr_q)
        4'd0:    ent = {E_CMD, 8'h01};
        4'd1:    ent = {E_DLY, 8'd120};
        4'd2:    ent = {E_CMD, 8'h11};
        4'd3:    ent = {E_DLY, 8'd120};
        4'd4:    ent = {E_CMD, 8'h3A};
        4'd5:    ent = {E_DAT, 8'h55};
        4'd6:    ent = {E_CMD, 8'h36};
        4'd7:    ent = {E_DAT, 8'h48};
        4'd8:    ent = {E_CMD, 8'h29};
        default: ent = {E_END, 8'h00};
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      loop_q    <= 1'b0;
      pix_q     <= '0;
      lo_byte_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      dc_q      <= 1'b0;
      sent_q    <= 1'b0;
      fdone_q   <= 1'b0;
`ifdef ILI_CMD_DELAY_EN
      dly_cnt_q <= '0;
`endif
    end else begin
      sent_q  <= 1'b0;
      fdone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_send_comm_ena) begin
            ptr_q   <= '0;
            loop_q  <= 1'b0;
            state_q <= i_command ? DONE : FETCH;
          end
        end
        DONE: begin
          if (!i_send_comm_ena) begin
            state_q <= IDLE;
          end else if (i_command) begin
            ptr_q   <= '0;
            loop_q  <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (!i_send_comm_ena) begin
            state_q <= IDLE;
          end else begin
            case (ent[9:8])
              E_CMD, E_DAT: begin
                valid_q <= 1'b1;
                data_q  <= DW'(ent[7:0]);
                dc_q    <= (ent[9:8] == E_DAT);
                state_q <= SEND;
              end
              E_DLY: begin
`ifdef ILI_CMD_DELAY_EN
                dly_cnt_q <= (ent[7:0] == 8'd0) ? '0
                           : DCW'(int'(ent[7:0]) * DELAY_UNIT_CYCLES - 1);
`endif
                state_q <= DELAY;
              end
              default: begin
                if (loop_q) begin
                  valid_q   <= 1'b1;
                  data_q    <= DW'(FILL_COLOR[15:8]);
                  dc_q      <= 1'b1;
                  lo_byte_q <= 1'b0;
                  pix_q     <= '0;
                  state_q   <= PIXEL;
                end else begin
                  sent_q  <= 1'b1;
                  state_q <= DONE;
                end
              end
            endcase
          end
        end
        SEND: begin
          if (xfer) begin
            valid_q <= 1'b0;
            ptr_q   <= ptr_q + 4'd1;
            state_q <= i_send_comm_ena ? FETCH : IDLE;
          end
        end
        DELAY: begin
          if (!i_send_comm_ena) begin
            state_q <= IDLE;
`ifdef ILI_CMD_DELAY_EN
          end else if (dly_cnt_q != '0) begin
            dly_cnt_q <= dly_cnt_q - 1'b1;
`endif
          end else begin
            ptr_q   <= ptr_q + 4'd1;
            state_q <= FETCH;
          end
        end
        PIXEL: begin
          // valid stays high across pixel bytes so the sender can stream them
          if (xfer) begin
            if (!i_send_comm_ena) begin
              valid_q <= 1'b0;
              state_q <= IDLE;
            end else if (!lo_byte_q) begin
              data_q    <= DW'(FILL_COLOR[7:0]);
              lo_byte_q <= 1'b1;
            end else if (pix_q == PCW'(NPIX - 1)) begin
              valid_q <= 1'b0;
              fdone_q <= 1'b1;
              ptr_q   <= '0;
              state_q <= i_command ? FETCH : DONE;
            end else begin
              pix_q     <= pix_q + 1'b1;
              data_q    <= DW'(FILL_COLOR[15:8]);
              lo_byte_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_spi_valid    = valid_q;
  assign o_spi_data     = data_q;
  assign o_spi_dc       = dc_q;
  assign o_command_sent = sent_q;
  assign o_frame_done   = fdone_q;
  assign o_busy         = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_ili_cmd_seq.sv
// Directed bench for ili_cmd_seq: init stream, frame fill, ready stalls,
// enable drop during pixels and reset during a delay.
module tb_ili_cmd_seq;
  localparam int DU = 4;
`ifdef ILI_CMD_DELAY_EN
  // 480 delay cycles plus FETCH before, FETCH and SEND after
  localparam int DLY_GAP = 120 * DU + 3;
`else
  localparam int DLY_GAP = 4;
`endif

  typedef struct {
    logic [7:0] data;
    logic       dc;
    int         gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, ena, cmd, ready;
  logic       valid, dc, sent, fdone, busy;
  logic [7:0] data;

  always #5 clk = ~clk;

  ili_cmd_seq #(.DW(8), .DELAY_UNIT_CYCLES(DU), .H_RES(2), .V_RES(2), .FILL_COLOR(16'h1234)) dut (
    .clk(clk), .rst(rst), .i_send_comm_ena(ena), .i_command(cmd), .i_spi_ready(ready),
    .o_spi_valid(valid), .o_spi_data(data), .o_spi_dc(dc),
    .o_command_sent(sent), .o_frame_done(fdone), .o_busy(busy));

  int vec_cnt = 0, err_cnt = 0;
  int cyc = 0, log_n = 0, sent_n = 0, fd_n = 0, fd_cyc = 0;
  logic [7:0] log_data [0:511];
  logic       log_dc   [0:511];
  int         log_cyc  [0:511];
  exp_t init_tbl [7];
  exp_t loop_tbl [19];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (valid && ready) begin
      if (log_n < 512) begin
        log_data[log_n] <= data;
        log_dc[log_n]   <= dc;
        log_cyc[log_n]  <= cyc;
      end
      log_n <= log_n + 1;
    end
    if (sent) sent_n <= sent_n + 1;
    if (fdone) begin
      fd_n   <= fd_n + 1;
      fd_cyc <= cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // sel: 0 = transfers logged, 1 = command_sent pulses, 2 = frame_done pulses, 3 = valid high
  function automatic bit cond_met(input int sel, input int target);
    case (sel)
      0:       return log_n >= target;
      1:       return sent_n >= target;
      2:       return fd_n >= target;
      default: return valid === 1'b1;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int target, input int budget, input string name);
    for (int k = 0; k < budget && !cond_met(sel, target); k++) begin
      @(posedge clk);
      #1;
    end
    if (!cond_met(sel, target)) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL timeout %s: condition not reached within %0d cycles", name, budget);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ena = 1'b0; cmd = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, ".valid"}, valid, 0);
    chk({tag, ".data"},  data,  0);
    chk({tag, ".dc"},    dc,    0);
    chk({tag, ".sent"},  sent,  0);
    chk({tag, ".fdone"}, fdone, 0);
    chk({tag, ".busy"},  busy,  0);
  endtask

  task automatic check_init(input int base, input string tag);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("%s[%0d].data", tag, i), log_data[base+i], init_tbl[i].data);
      chk($sformatf("%s[%0d].dc", tag, i), log_dc[base+i], init_tbl[i].dc);
      if (i > 0)
        chk($sformatf("%s[%0d].gap", tag, i), log_cyc[base+i] - log_cyc[base+i-1], init_tbl[i].gap);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, sb, fb, n3a;
    init_tbl[0] = '{8'h01, 1'b0, 0};
    init_tbl[1] = '{8'h11, 1'b0, DLY_GAP};
    init_tbl[2] = '{8'h3A, 1'b0, DLY_GAP};
    init_tbl[3] = '{8'h55, 1'b1, 2};
    init_tbl[4] = '{8'h36, 1'b0, 2};
    init_tbl[5] = '{8'h48, 1'b1, 2};
    init_tbl[6] = '{8'h29, 1'b0, 2};
    loop_tbl[0]  = '{8'h2A, 1'b0, 2};
    loop_tbl[1]  = '{8'h00, 1'b1, 2};
    loop_tbl[2]  = '{8'h00, 1'b1, 2};
    loop_tbl[3]  = '{8'h00, 1'b1, 2};
    loop_tbl[4]  = '{8'h01, 1'b1, 2};
    loop_tbl[5]  = '{8'h2B, 1'b0, 2};
    loop_tbl[6]  = '{8'h00, 1'b1, 2};
    loop_tbl[7]  = '{8'h00, 1'b1, 2};
    loop_tbl[8]  = '{8'h00, 1'b1, 2};
    loop_tbl[9]  = '{8'h01, 1'b1, 2};
    loop_tbl[10] = '{8'h2C, 1'b0, 2};
    loop_tbl[11] = '{8'h12, 1'b1, 2};
    for (int i = 12; i < 19; i++)
      loop_tbl[i] = '{(i % 2 == 0) ? 8'h34 : 8'h12, 1'b1, 1};

    // reset state
    rst = 1'b1; ena = 1'b0; cmd = 1'b0; ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1 chk("idle.busy", busy, 0);

    // init stream
    base = log_n; sb = sent_n;
    ena = 1'b1;
    wait_for(1, sb + 1, 3000, "init command_sent");
    repeat (5) @(posedge clk);
    #1;
    chk("init.sent_pulses", sent_n - sb, 1);
    chk("init.bytes", log_n - base, 7);
    check_init(base, "init");
    chk("init.done_busy", busy, 0);
    chk("init.done_valid", valid, 0);

    // two frames of the fill loop
    base = log_n; fb = fd_n;
    cmd = 1'b1;
    wait_for(2, fb + 2, 300, "loop frame_done");
    for (int i = 0; i < 38; i++) begin
      chk($sformatf("loop[%0d].data", i), log_data[base+i], loop_tbl[i%19].data);
      chk($sformatf("loop[%0d].dc", i), log_dc[base+i], loop_tbl[i%19].dc);
      if (i > 0)
        chk($sformatf("loop[%0d].gap", i), log_cyc[base+i] - log_cyc[base+i-1], loop_tbl[i%19].gap);
    end
    chk("loop.fdone_timing", fd_cyc - log_cyc[base+37], 1);
    chk("loop.busy_restart", busy, 1);

    // ready held low while 0x3A is presented
    do_reset();
    base = log_n; sb = sent_n;
    ena = 1'b1; cmd = 1'b0;
    wait_for(0, base + 2, 2000, "stall first bytes");
    ready = 1'b0;
    wait_for(3, 0, 1000, "stall valid");
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("stall[%0d].valid", k), valid, 1);
      chk($sformatf("stall[%0d].data", k), data, 8'h3A);
      chk($sformatf("stall[%0d].dc", k), dc, 0);
      @(posedge clk);
      #1;
    end
    chk("stall.no_xfer", log_n - base, 2);
    ready = 1'b1;
    wait_for(1, sb + 1, 200, "stall command_sent");
    n3a = 0;
    for (int i = base; i < log_n; i++)
      if (log_data[i] == 8'h3A) n3a++;
    chk("stall.count_3A", n3a, 1);
    chk("stall.bytes", log_n - base, 7);

    // enable dropped while a pixel byte waits for ready
    do_reset();
    sb = sent_n;
    ena = 1'b1; cmd = 1'b0;
    wait_for(1, sb + 1, 3000, "pixdrop init");
    base = log_n;
    cmd = 1'b1;
    wait_for(0, base + 11, 200, "pixdrop header");
    chk("pixdrop.last_hdr", log_data[base+10], 8'h2C);
    ready = 1'b0;
    wait_for(3, 0, 20, "pixdrop valid");
    ena = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pixdrop.hold_valid", valid, 1);
    chk("pixdrop.hold_data", data, 8'h12);
    chk("pixdrop.hold_dc", dc, 1);
    chk("pixdrop.hold_busy", busy, 1);
    ready = 1'b1;
    @(posedge clk);
    #1;
    chk("pixdrop.after_valid", valid, 0);
    chk("pixdrop.after_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("pixdrop.idle_valid", valid, 0);
    chk("pixdrop.bytes", log_n - base, 12);
    chk("pixdrop.last_byte", log_data[base+11], 8'h12);

    // reset during the first delay
    do_reset();
    base = log_n;
    ena = 1'b1; cmd = 1'b0;
    wait_for(0, base + 1, 100, "rstdly first byte");
    repeat (5) @(posedge clk);
    #1 chk("rstdly.busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check_outputs_zero("rstdly");
    @(posedge clk);
    #1 rst = 1'b0;
    base = log_n; sb = sent_n;
    wait_for(1, sb + 1, 3000, "rstdly command_sent");
    chk("rstdly.bytes", log_n - base, 7);
    check_init(base, "rstdly");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
